// File: rtl/ariane_axi.sv
// AXI4 channel and bundle types (64-bit address and data, 4-bit ID) shared by
// the dcache refill/bypass ports and the memory responder.
package ariane_axi;

  localparam int IdW = 4;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [63:0]    addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
    logic [5:0]     atop;
  } aw_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [63:0]    addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [63:0]    data;
    logic [1:0]     resp;
    logic           last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI4 subordinate backed by a 64-bit word memory.
// Define AXI_MEM_DELAY_EN to insert ReadDelay wait cycles before the first R beat.
module axi_mem_responder #(
  parameter logic [63:0] BaseAddr  = 64'h8000_0000,
  parameter int unsigned MemWords  = 1024,
  parameter int unsigned ReadDelay = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  ariane_axi::req_t  axi_req_i,
  output ariane_axi::resp_t axi_resp_o,
  output logic              busy_o
);

  localparam int unsigned IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam logic [63:0] MemBytes = 64'(MemWords) << 3;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  generate
    if (MemWords < 2 || (MemWords & (MemWords - 1)) != 0 || ReadDelay > 255) begin : g_bad_cfg
      $error("axi_mem_responder: MemWords must be a power of two >= 2 and ReadDelay <= 255");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_RESP} state_e;

  function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] incr;
    logic [63:0] wmask;
    incr  = a + (64'd1 << size);
    wmask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      BurstFixed: return a;
      BurstWrap:  return (a & ~wmask) | (incr & wmask);
      default:    return incr;
    endcase
  endfunction

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BaseAddr) && ((a - BaseAddr) < MemBytes);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [63:0] a);
    return IdxW'((a - BaseAddr) >> 3);
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_e                      r_state;
  logic [ariane_axi::IdW-1:0]  r_id;
  logic [63:0]                 r_addr;
  logic [7:0]                  r_len;
  logic [2:0]                  r_size;
  logic [1:0]                  r_burst;
  logic [5:0]                  r_atop;
  logic [7:0]                  r_beat_cnt;
  logic [1:0]                  r_bresp;
  logic                        r_prio_wr;
  logic                        r_hold;
`ifdef AXI_MEM_DELAY_EN
  logic [7:0]                  r_dly_cnt;
`endif
  logic [63:0]                 mem [MemWords];

  logic            w_idle_open;
  logic            w_ar_ready;
  logic            w_aw_ready;
  logic            w_ar_hs;
  logic            w_aw_hs;
  logic            w_both_valid;
  logic            w_in_range;
  logic [IdxW-1:0] w_idx;
  logic [1:0]      w_beat_resp;
  logic            w_last_beat;
  logic [1:0]      w_wr_resp;
  logic            w_mem_we;

  // r_hold blocks acceptance for the first IDLE cycle after a transaction ends
  assign w_idle_open  = (r_state == IDLE) && !r_hold && !rst_i;
  assign w_both_valid = axi_req_i.ar_valid && axi_req_i.aw_valid;
  assign w_ar_ready   = w_idle_open && (!axi_req_i.aw_valid || !r_prio_wr);
  assign w_aw_ready   = w_idle_open && (!axi_req_i.ar_valid || r_prio_wr);
  assign w_ar_hs      = w_ar_ready && axi_req_i.ar_valid;
  assign w_aw_hs      = w_aw_ready && axi_req_i.aw_valid;

  assign w_in_range  = in_range(r_addr);
  assign w_idx       = word_idx(r_addr);
  assign w_beat_resp = !w_in_range ? RespDecErr : ((r_atop != '0) ? RespSlvErr : RespOkay);
  assign w_last_beat = (r_beat_cnt == r_len);
  assign w_wr_resp   = worst(w_beat_resp,
                             (axi_req_i.w.last != w_last_beat) ? RespSlvErr : RespOkay);
  assign w_mem_we    = (r_state == WR_BEAT) && axi_req_i.w_valid && w_in_range && (r_atop == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_atop     <= '0;
      r_beat_cnt <= '0;
      r_bresp    <= RespOkay;
      r_prio_wr  <= 1'b0;
      r_hold     <= 1'b0;
`ifdef AXI_MEM_DELAY_EN
      r_dly_cnt  <= '0;
`endif
    end else begin
      r_hold <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ar_hs) begin
            r_id       <= axi_req_i.ar.id;
            r_addr     <= axi_req_i.ar.addr;
            r_len      <= axi_req_i.ar.len;
            r_size     <= axi_req_i.ar.size;
            r_burst    <= axi_req_i.ar.burst;
            r_atop     <= '0;
            r_beat_cnt <= '0;
            if (w_both_valid) r_prio_wr <= ~r_prio_wr;
`ifdef AXI_MEM_DELAY_EN
            if (ReadDelay == 0) begin
              r_state <= RD_BEAT;
            end else begin
              r_state   <= RD_WAIT;
              r_dly_cnt <= 8'(ReadDelay - 1);
            end
`else
            r_state <= RD_BEAT;
`endif
          end else if (w_aw_hs) begin
            r_id       <= axi_req_i.aw.id;
            r_addr     <= axi_req_i.aw.addr;
            r_len      <= axi_req_i.aw.len;
            r_size     <= axi_req_i.aw.size;
            r_burst    <= axi_req_i.aw.burst;
            r_atop     <= axi_req_i.aw.atop;
            r_beat_cnt <= '0;
            r_bresp    <= RespOkay;
            if (w_both_valid) r_prio_wr <= ~r_prio_wr;
            r_state    <= WR_BEAT;
          end
        end
`ifdef AXI_MEM_DELAY_EN
        RD_WAIT: begin
          if (r_dly_cnt == '0) r_state <= RD_BEAT;
          else                 r_dly_cnt <= r_dly_cnt - 8'd1;
        end
`endif
        RD_BEAT: begin
          if (axi_req_i.r_ready) begin
            if (w_last_beat) begin
              r_state <= IDLE;
              r_hold  <= 1'b1;
            end else begin
              r_addr     <= next_addr(r_addr, r_len, r_size, r_burst);
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        WR_BEAT: begin
          if (axi_req_i.w_valid) begin
            r_bresp <= worst(r_bresp, w_wr_resp);
            if (axi_req_i.w.last || w_last_beat) begin
              r_state <= WR_RESP;
            end else begin
              r_addr     <= next_addr(r_addr, r_len, r_size, r_burst);
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        WR_RESP: begin
          if (axi_req_i.b_ready) begin
            r_state <= IDLE;
            r_hold  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (axi_req_i.w.strb[b]) mem[w_idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
      end
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.ar_ready = w_ar_ready;
    axi_resp_o.aw_ready = w_aw_ready;
    axi_resp_o.w_ready  = (r_state == WR_BEAT);
    if (r_state == RD_BEAT) begin
      axi_resp_o.r_valid = 1'b1;
      axi_resp_o.r.id    = r_id;
      axi_resp_o.r.data  = w_in_range ? mem[w_idx] : '0;
      axi_resp_o.r.resp  = w_beat_resp;
      axi_resp_o.r.last  = w_last_beat;
    end
    if (r_state == WR_RESP) begin
      axi_resp_o.b_valid = 1'b1;
      axi_resp_o.b.id    = r_id;
      axi_resp_o.b.resp  = r_bresp;
    end
  end

  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: a word-level memory model and response
// queues predict every R/B beat; literal checks pin the model on key cases.
module tb_axi_mem_responder;
  import ariane_axi::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          WORDS = 1024;
`ifdef AXI_MEM_DELAY_EN
  localparam int EXP_LAT = 5;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  req_t  axi_req;
  resp_t axi_resp;
  logic  busy;

  ar_chan_t ar_c;
  aw_chan_t aw_c;
  w_chan_t  w_c;
  logic ar_v, aw_v, w_v, r_rdy, b_rdy;

  always #5 clk_i = ~clk_i;

  always_comb begin
    axi_req          = '0;
    axi_req.ar       = ar_c;
    axi_req.ar_valid = ar_v;
    axi_req.aw       = aw_c;
    axi_req.aw_valid = aw_v;
    axi_req.w        = w_c;
    axi_req.w_valid  = w_v;
    axi_req.r_ready  = r_rdy;
    axi_req.b_ready  = b_rdy;
  end

  axi_mem_responder #(.BaseAddr(BASE), .MemWords(WORDS), .ReadDelay(4)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .axi_req_i (axi_req),
    .axi_resp_o(axi_resp),
    .busy_o    (busy)
  );

  rbeat_t      exp_r[$];
  rbeat_t      got_r[$];
  logic [5:0]  exp_b[$];
  logic [5:0]  got_b[$];
  logic [63:0] mm [WORDS];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ar_cyc = 0;
  int last_aw_cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endfunction

  function automatic void fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: expected event missing or unexpected event seen", nm);
  endfunction

  function automatic logic m_ok(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * WORDS));
  endfunction

  function automatic int m_idx(input logic [63:0] a);
    return int'(((a - BASE) >> 3) % 64'(WORDS));
  endfunction

  // Address of beat i, written as offsets from the start address
  function automatic logic [63:0] m_addr(input logic [63:0] start, input int i, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] nb, wsz, base;
    nb = 64'd1 << size;
    case (burst)
      2'b00: return start;
      2'b10: begin
        wsz  = (64'(len) + 1) * nb;
        base = start - (start % wsz);
        return base + (((start - base) + 64'(i) * nb) % wsz);
      end
      default: return start + 64'(i) * nb;
    endcase
  endfunction

  always @(negedge clk_i) begin
    rbeat_t g;
    if (!rst_i) begin
      if (axi_resp.r_valid) begin
        if (exp_r.size() == 0) fail("r_unexpected");
        else begin
          chk("r_id",   64'(axi_resp.r.id),   64'(exp_r[0].id));
          chk("r_data", axi_resp.r.data,      exp_r[0].data);
          chk("r_resp", 64'(axi_resp.r.resp), 64'(exp_r[0].resp));
          chk("r_last", 64'(axi_resp.r.last), 64'(exp_r[0].last));
          if (r_rdy) begin
            g.id = axi_resp.r.id; g.data = axi_resp.r.data;
            g.resp = axi_resp.r.resp; g.last = axi_resp.r.last;
            got_r.push_back(g);
            void'(exp_r.pop_front());
          end
        end
      end
      if (axi_resp.b_valid) begin
        if (exp_b.size() == 0) fail("b_unexpected");
        else begin
          chk("b_id_resp", 64'({axi_resp.b.id, axi_resp.b.resp}), 64'(exp_b[0]));
          if (b_rdy) begin
            got_b.push_back({axi_resp.b.id, axi_resp.b.resp});
            void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_ready(input int ch, input string nm, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if ((ch == 0 && axi_resp.ar_ready) || (ch == 1 && axi_resp.aw_ready) ||
          (ch == 2 && axi_resp.w_ready)) ok = 1'b1;
      @(posedge clk_i); #1;
      if (ok) break;
    end
    if (!ok) fail(nm);
  endtask

  task automatic rd(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                    input logic [1:0] burst, input logic [3:0] id);
    bit ok;
    int lat;
    rbeat_t e;
    logic [63:0] a;
    @(posedge clk_i); #1;
    ar_c.id = id; ar_c.addr = addr; ar_c.len = len; ar_c.size = size; ar_c.burst = burst;
    ar_v = 1'b1;
    wait_ready(0, "ar_timeout", ok);
    ar_v = 1'b0;
    last_ar_cyc = cyc;
    if (ok) begin
      for (int i = 0; i <= int'(len); i++) begin
        a = m_addr(addr, i, len, size, burst);
        e.id   = id;
        e.data = m_ok(a) ? mm[m_idx(a)] : 64'd0;
        e.resp = m_ok(a) ? 2'b00 : 2'b11;
        e.last = (i == int'(len));
        exp_r.push_back(e);
      end
      lat = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk_i);
        lat++;
        if (axi_resp.r_valid || rst_i) break;
      end
      if (!rst_i) chk("r_latency", 64'(lat), 64'(EXP_LAT));
      for (int k = 0; k < 400; k++) begin
        if (exp_r.size() == 0) break;
        @(posedge clk_i); #1;
      end
      if (exp_r.size() != 0) begin
        fail("r_drain");
        exp_r.delete();
      end
    end
  endtask

  task automatic wr(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                    input logic [1:0] burst, input logic [3:0] id, input logic [5:0] atop,
                    input int nb);
    bit ok;
    logic [1:0] resp;
    logic [63:0] a;
    @(posedge clk_i); #1;
    aw_c.id = id; aw_c.addr = addr; aw_c.len = len; aw_c.size = size;
    aw_c.burst = burst; aw_c.atop = atop;
    aw_v = 1'b1;
    wait_ready(1, "aw_timeout", ok);
    aw_v = 1'b0;
    last_aw_cyc = cyc;
    if (ok) begin
      resp = (nb != int'(len) + 1) ? 2'b10 : 2'b00;
      for (int i = 0; i < nb && i <= int'(len); i++) begin
        w_c.data = wd[i]; w_c.strb = ws[i]; w_c.last = (i == nb - 1);
        w_v = 1'b1;
        wait_ready(2, "w_timeout", ok);
        if (!ok) break;
        a = m_addr(addr, i, len, size, burst);
        if (!m_ok(a)) resp = 2'b11;
        else if (atop != 0) begin
          if (resp < 2'b10) resp = 2'b10;
        end else begin
          for (int b = 0; b < 8; b++)
            if (ws[i][b]) mm[m_idx(a)][8*b +: 8] = wd[i][8*b +: 8];
        end
      end
      w_v = 1'b0;
      w_c.last = 1'b0;
      if (ok) begin
        exp_b.push_back({id, resp});
        for (int k = 0; k < 100; k++) begin
          if (exp_b.size() == 0) break;
          @(posedge clk_i); #1;
        end
        if (exp_b.size() != 0) begin
          fail("b_drain");
          exp_b.delete();
        end
      end
    end
  endtask

  initial begin
    int g0, gb;
    bit seen;
    ar_c = '0; aw_c = '0; w_c = '0;
    ar_v = 1'b0; aw_v = 1'b0; w_v = 1'b0; r_rdy = 1'b1; b_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 8'hFF; end

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready",  64'({axi_resp.ar_ready, axi_resp.aw_ready, axi_resp.w_ready}), 64'd0);
    chk("rst_valid",  64'({axi_resp.r_valid, axi_resp.b_valid}), 64'd0);
    chk("rst_rdata",  axi_resp.r.data, 64'd0);
    chk("rst_fields", 64'({axi_resp.r.id, axi_resp.r.resp, axi_resp.r.last,
                           axi_resp.b.id, axi_resp.b.resp}), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    w_c.data = 64'hFFFF_0000_FFFF_0000; w_c.strb = 8'hFF; w_v = 1'b1;
    @(negedge clk_i);
    chk("w_early_ready", 64'(axi_resp.w_ready), 64'd0);
    @(posedge clk_i); #1;
    w_v = 1'b0;

    // Preload: words 0..3 and word 512
    wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
    wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
    wr(BASE, 8'd3, 3'd3, 2'b01, 4'd1, 6'd0, 4);
    wd[0] = 64'h5555_5555_5555_5555;
    wr(BASE + 64'h1000, 8'd0, 3'd3, 2'b01, 4'd1, 6'd0, 1);

    // Arbitration: read wins first, then write
    wd[0] = 64'h8888_8888_8888_8888;
    fork
      rd(BASE, 8'd0, 3'd3, 2'b01, 4'd2);
      wr(BASE + 64'h40, 8'd0, 3'd3, 2'b01, 4'd3, 6'd0, 1);
    join
    chk("arb1_read_first", 64'(last_ar_cyc < last_aw_cyc), 64'd1);
    wd[0] = 64'h9999_9999_9999_9999;
    fork
      rd(BASE + 64'h8, 8'd0, 3'd3, 2'b01, 4'd2);
      wr(BASE + 64'h48, 8'd0, 3'd3, 2'b01, 4'd3, 6'd0, 1);
    join
    chk("arb2_write_first", 64'(last_aw_cyc < last_ar_cyc), 64'd1);

    // Refill
    g0 = got_r.size();
    rd(BASE, 8'd3, 3'd3, 2'b01, 4'd5);
    chk("refill_beats", 64'(got_r.size() - g0), 64'd4);
    if (got_r.size() >= g0 + 4) begin
      chk("refill_d0",   got_r[g0].data,   64'h1111_1111_1111_1111);
      chk("refill_d3",   got_r[g0+3].data, 64'h4444_4444_4444_4444);
      chk("refill_last2", 64'(got_r[g0+2].last), 64'd0);
      chk("refill_last3", 64'(got_r[g0+3].last), 64'd1);
      chk("refill_id",   64'(got_r[g0+3].id), 64'd5);
    end

    // Write-back with partial strobe
    wd[0] = 64'hAAAA_BBBB_CCCC_DDDD; ws[0] = 8'hFF;
    wd[1] = 64'h0;                   ws[1] = 8'h0F;
    gb = got_b.size();
    wr(BASE + 64'h10, 8'd1, 3'd3, 2'b01, 4'd6, 6'd0, 2);
    ws[1] = 8'hFF;
    if (got_b.size() > gb) chk("wb_bresp", 64'(got_b[gb][1:0]), 64'd0);
    else fail("wb_bresp");
    g0 = got_r.size();
    rd(BASE + 64'h10, 8'd1, 3'd3, 2'b01, 4'd6);
    if (got_r.size() >= g0 + 2) begin
      chk("wb_word2", got_r[g0].data,   64'hAAAA_BBBB_CCCC_DDDD);
      chk("wb_word3", got_r[g0+1].data, 64'h4444_4444_0000_0000);
    end else fail("wb_readback");

    // Backpressure: stall three cycles with beat 3 presented
    g0 = got_r.size();
    fork
      rd(BASE, 8'd3, 3'd3, 2'b01, 4'd7);
      begin
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(posedge clk_i); #1;
          if (got_r.size() >= g0 + 2) begin seen = 1'b1; break; end
        end
        if (!seen) fail("bp_start");
        r_rdy = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 r_rdy = 1'b1;
      end
    join
    chk("bp_beats", 64'(got_r.size() - g0), 64'd4);
    if (got_r.size() >= g0 + 4) chk("bp_d2", got_r[g0+2].data, 64'hAAAA_BBBB_CCCC_DDDD);

    // Decode error on read and write; aliased word 512 must be untouched
    g0 = got_r.size();
    rd(64'h1000, 8'd0, 3'd3, 2'b01, 4'd8);
    if (got_r.size() > g0) begin
      chk("dec_rresp", 64'(got_r[g0].resp), 64'd3);
      chk("dec_rdata", got_r[g0].data, 64'd0);
    end else fail("dec_read");
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    gb = got_b.size();
    wr(64'h1000, 8'd0, 3'd3, 2'b01, 4'd9, 6'd0, 1);
    if (got_b.size() > gb) chk("dec_bresp", 64'(got_b[gb][1:0]), 64'd3);
    else fail("dec_bresp");
    g0 = got_r.size();
    rd(BASE + 64'h1000, 8'd0, 3'd3, 2'b01, 4'd1);
    if (got_r.size() > g0) chk("dec_alias_kept", got_r[g0].data, 64'h5555_5555_5555_5555);

    // Atomic write: SLVERR, memory untouched
    gb = got_b.size();
    wr(BASE, 8'd0, 3'd3, 2'b01, 4'd4, 6'h20, 1);
    if (got_b.size() > gb) chk("atop_bresp", 64'(got_b[gb][1:0]), 64'd2);
    else fail("atop_bresp");
    g0 = got_r.size();
    rd(BASE, 8'd0, 3'd3, 2'b01, 4'd4);
    if (got_r.size() > g0) chk("atop_kept", got_r[g0].data, 64'h1111_1111_1111_1111);

    // w_last arrives before len: burst ends, SLVERR, beat still written
    wd[0] = 64'h7777_7777_7777_7777;
    gb = got_b.size();
    wr(BASE + 64'h20, 8'd1, 3'd3, 2'b01, 4'd4, 6'd0, 1);
    if (got_b.size() > gb) chk("short_bresp", 64'(got_b[gb][1:0]), 64'd2);
    else fail("short_bresp");
    g0 = got_r.size();
    rd(BASE + 64'h20, 8'd0, 3'd3, 2'b01, 4'd4);
    if (got_r.size() > g0) chk("short_word", got_r[g0].data, 64'h7777_7777_7777_7777);

    // WRAP and FIXED bursts
    g0 = got_r.size();
    rd(BASE + 64'h10, 8'd3, 3'd3, 2'b10, 4'd2);
    if (got_r.size() >= g0 + 4) chk("wrap_d2", got_r[g0+2].data, 64'h1111_1111_1111_1111);
    else fail("wrap_beats");
    g0 = got_r.size();
    rd(BASE + 64'h8, 8'd1, 3'd3, 2'b00, 4'd3);
    if (got_r.size() >= g0 + 2) chk("fixed_d1", got_r[g0+1].data, 64'h2222_2222_2222_2222);
    else fail("fixed_beats");

    // Reset during beat 2 of a 4-beat read
    g0 = got_r.size();
    fork
      rd(BASE, 8'd3, 3'd3, 2'b01, 4'd1);
      begin
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(posedge clk_i); #1;
          if (got_r.size() >= g0 + 1) begin seen = 1'b1; break; end
        end
        if (!seen) fail("rst_mid_start");
        #1 rst_i = 1'b1;
        #1;
        chk("rst_mid_rvalid", 64'(axi_resp.r_valid), 64'd0);
        chk("rst_mid_busy",   64'(busy), 64'd0);
        exp_r.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
      end
    join
    chk("rst_mid_beats", 64'(got_r.size() - g0), 64'd1);
    g0 = got_r.size();
    rd(BASE + 64'h8, 8'd0, 3'd3, 2'b01, 4'd2);
    if (got_r.size() > g0) chk("post_rst_read", got_r[g0].data, 64'h2222_2222_2222_2222);
    else fail("post_rst_read");

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 subordinate that services the L1 dcache's refill and bypass AXI ports: line refills (read bursts), write-backs (write bursts) and uncached single beats.
- Backed by an internal word-addressed memory of MemWords 64-bit words.
- Used as the memory end of dcache-level benches and as a small on-chip scratch memory behind the cache subsystem.
- One transaction in flight at a time; responses are in order; ID is echoed.

Parameters:
- BaseAddr, 64'h8000_0000, first byte address mapped to memory word 0.
- MemWords, 1024, number of 64-bit words; power of two, ≥ 2.
- ReadDelay, 4, cycles between AR acceptance and the first R beat. Used only with AXI_MEM_DELAY_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- axi_req_i  in  ariane_axi::req_t  AW/W/AR channels plus b_ready and r_ready from the initiator
- axi_resp_o  out  ariane_axi::resp_t  aw_ready, w_ready, ar_ready, B and R channels
- busy_o  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset: every ready and valid in axi_resp_o = 0, every resp/data/id/last field = 0, busy_o = 0, FSM = IDLE, priority bit = read. Memory contents are not reset.
- Reset mid-burst aborts the transaction immediately; no further beats are issued.
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_RESP.
- IDLE: ar_ready/aw_ready are high combinationally in IDLE, gated by arbitration.
  - If only one of ar_valid/aw_valid is high, that channel is accepted.
  - If both are high in the same cycle, the channel named by the priority bit wins; the priority bit then flips, giving round-robin.
  - Accept registers id, addr, len, size, burst and atop.
- Read acceptance: goes to RD_WAIT if AXI_MEM_DELAY_EN is defined, otherwise directly to RD_BEAT.
  - The first R beat is valid in the cycle after AR acceptance (latency 1).
- RD_BEAT:
  - r_valid = 1; r_data = mem[idx]; r_id = stored id; r_last = (beat_cnt == len).
  - On r_valid & r_ready: beat_cnt increments and the address advances.
  - If r_last, return to IDLE.
  - r_valid must stay asserted with stable data while r_ready is low.
- Write acceptance: goes to WR_BEAT with w_ready = 1.
  - Each beat with w_valid & w_ready writes the bytes selected by w_strb into mem[idx].
  - The address advances each beat.
  - w_last, or beat_cnt == len, moves to WR_RESP.
  - A w_last / len mismatch is recorded as SLVERR; the burst ends at whichever comes first.
- WR_RESP: b_valid = 1, b_id = stored id, b_resp = accumulated status. Held until b_ready, then return to IDLE.
- W data arriving before AW is accepted is not consumed (w_ready = 0 outside WR_BEAT).
- Index and address arithmetic:
  - idx = ((addr − BaseAddr) >> 3) mod MemWords.
  - INCR: addr += 1 << size.
  - FIXED: addr unchanged.
  - WRAP: wraps at boundary (len+1) << size.
  - beat_cnt is 8 bits, so a maximum of 256 beats.
- Response codes:
  - Address outside [BaseAddr, BaseAddr + 8·MemWords), checked on every beat: resp = DECERR (2'b11), r_data = 0, write dropped.
  - atop ≠ 0: SLVERR (2'b10) on every R beat / B; memory untouched, but all beats are still transferred.
  - Otherwise resp = OKAY.
  - B carries the worst status seen over the burst.
- Simultaneous events: the cycle a transaction returns to IDLE, no new AR/AW is accepted; acceptance starts in the following cycle.

Optional Feature:
- Macro: AXI_MEM_DELAY_EN.
- Defined: after AR acceptance the FSM sits in RD_WAIT for ReadDelay cycles, counted by an 8-bit down-counter, then enters RD_BEAT.
  - First R beat appears ReadDelay+1 cycles after the AR handshake.
  - ReadDelay = 0 behaves as if the macro were undefined.
- Undefined: RD_WAIT and its counter are not compiled; first-beat latency is 1 cycle.

Test Plan:
- Refill: preload mem words 0..3 = 64'h1111..4444; AR addr 0x8000_0000, len 3, INCR, size 3, id 5 → 4 R beats with data in order, r_id 5, r_last only on beat 4, resp OKAY.
- Write-back: AW addr 0x8000_0010, len 1; W beats 64'hAAAA_BBBB_CCCC_DDDD with strb 0xFF, then 64'h0 with strb 0x0F → B OKAY; a later read shows word 2 = AAAA…, word 3 low 4 bytes = 0 and high 4 bytes preserved.
- Backpressure: hold r_ready = 0 for 3 cycles mid-burst → r_valid stays 1 and r_data is stable; no beat is lost or duplicated.
- Decode error: AR addr 0x0000_1000 → single R beat with resp 2'b11, data 0; AW to the same address → B 2'b11 and memory unchanged.
- Arbitration: AR and AW valid in the same cycle after reset → read served first; repeat → write served first.
- Reset mid-read: assert rst_i during beat 2 of a 4-beat read → r_valid = 0 the same cycle; busy_o = 0; the next AR is served normally.
